float_discriminant_issuer: RTL and testbench
============================================

Name: float_discriminant_issuer

Overview:
Initiator side of the discriminant-engine handshake. Buffers coefficient triples {a,b,c} from an upstream producer and issues them one at a time to a discriminant engine (arg_vld/busy in, res_vld/res/res_negative/err out), honouring engine busy. Collects each result, tags it with a sequence number and presents it downstream with a valid/ready handshake. Adds a NaN/Inf pre-check bypass and a response timeout.

Parameters:
DEPTH, 4, coefficient queue entries (power of 2, >=2)
TIMEOUT, 64, max cycles from issue to eng_res_vld before timeout
TAG_W, 4, width of result sequence tag
(FLEN comes from the shared config header; it is not a parameter)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_vld  in  1  upstream triple valid
in_rdy  out  1  queue not full
in_a  in  FLEN  coefficient a
in_b  in  FLEN  coefficient b
in_c  in  FLEN  coefficient c
eng_arg_vld  out  1  one-cycle issue strobe to engine
eng_a  out  FLEN  to engine
eng_b  out  FLEN  to engine
eng_c  out  FLEN  to engine
eng_busy  in  1  engine busy
eng_res_vld  in  1  engine result strobe
eng_res  in  FLEN  engine result
eng_res_negative  in  1  engine sign flag
eng_err  in  1  engine error
out_vld  out  1  result valid
out_rdy  in  1  downstream ready
out_res  out  FLEN  discriminant
out_negative  out  1  result negative
out_err  out  1  engine err or pre-check err
out_timeout  out  1  engine did not respond
out_tag  out  TAG_W  sequence number
spurious  out  1  sticky: eng_res_vld seen outside WAIT

Behaviour:
- Reset: all outputs 0, queue empty, FSM IDLE, tag counter 0, timeout counter 0, spurious 0. in_rdy goes 1 the cycle after rst deasserts.
- Queue: push when in_vld & in_rdy; in_rdy = !full (no same-cycle pop-through when full). Pointers wrap modulo DEPTH; count distinguishes full/empty. Push and pop in the same cycle allowed when not full.
- FSM states: IDLE, ISSUE, WAIT, OUT.
- IDLE: if queue non-empty: pre-check head; if any of a,b,c has exponent all-ones (NaN/Inf) -> pop, load out_res=0, out_err=1, out_negative=0, out_timeout=0, go OUT (engine not used). Else if !eng_busy -> ISSUE.
- ISSUE (exactly 1 cycle): eng_arg_vld=1, eng_a/b/c = head, pop; clear timeout counter; go WAIT. eng_a/b/c hold last issued values otherwise.
- WAIT: counter increments each cycle. On eng_res_vld: capture res, negative, err; out_timeout=0; go OUT. eng_res_vld wins if on the same cycle counter reaches TIMEOUT-1. Counter == TIMEOUT-1 with no response: out_res=0, out_err=1, out_timeout=1, go OUT.
- OUT: out_vld=1, fields stable until out_vld & out_rdy; then tag increments (wraps at 2^TAG_W), go IDLE. Minimum issue-to-issue spacing: 4 cycles.
- Only one request outstanding; eng_arg_vld never asserted while eng_busy=1 or in WAIT/OUT.
- eng_res_vld in IDLE/ISSUE/OUT: ignored for data, sets spurious (cleared only by rst).
- Reset mid-operation: queue flushed, in-flight request abandoned, tag to 0; any eng_res_vld in the cycle rst is high is ignored and does not set spurious.
- Latency (empty queue, idle engine): push at cycle 0 -> eng_arg_vld at cycle 2 -> out_vld 1 cycle after eng_res_vld.

Decomposition:
- Shared package: FSM state enum, fp64 exponent field constants (EXP_MSB, EXP_LSB), is_nan_or_inf function.
- Sub-module: float_triple_fifo (DEPTH x 3*FLEN, push/pop, full/empty).

Test Plan:
- a=3FF0_0000_0000_0000 (1.0), b=4008_0000_0000_0000 (3.0), c=4000_0000_0000_0000 (2.0), engine returns 3FF0_0000_0000_0000 -> out_res=1.0, out_negative=0, out_err=0, out_tag=0.
- Push 5 triples back-to-back with DEPTH=4, out_rdy=1 -> in_rdy drops after 4th push (low while full), all 5 results in order with tags 0..4, one eng_arg_vld per triple.
- b=7FF0_0000_0000_0000 (+Inf) -> no eng_arg_vld, out_err=1, out_res=0, within 2 cycles of reaching queue head.
- Engine silent after issue -> out_timeout=1, out_err=1 exactly TIMEOUT cycles after eng_arg_vld; next triple then issues normally.
- eng_busy=1 held 10 cycles with queue non-empty -> no eng_arg_vld until cycle after eng_busy falls; stray eng_res_vld in IDLE -> spurious=1, outputs unchanged.
- out_rdy=0 for 8 cycles in OUT -> out_* stable; rst in WAIT -> all outputs 0, queue empty, tag restarts at 0.

Source files
------------

// File: rtl/float_discriminant_issuer_pkg.sv
// Shared types and fp64 field helpers for the discriminant issuer.
package float_discriminant_issuer_pkg;

    localparam int FLEN    = 64;
    localparam int EXP_MSB = 62;
    localparam int EXP_LSB = 52;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        OUT
    } state_t;

    typedef struct packed {
        logic [FLEN-1:0] a;
        logic [FLEN-1:0] b;
        logic [FLEN-1:0] c;
    } triple_t;

    function automatic logic is_nan_or_inf(input logic [FLEN-1:0] x);
        return &x[EXP_MSB:EXP_LSB];
    endfunction

    function automatic logic triple_special(input triple_t t);
        return is_nan_or_inf(t.a) | is_nan_or_inf(t.b) | is_nan_or_inf(t.c);
    endfunction

endpackage

// File: rtl/float_triple_fifo.sv
// Coefficient-triple queue; count disambiguates full from empty.
module float_triple_fifo
    import float_discriminant_issuer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  logic    pop,
    input  triple_t wdata,
    output triple_t rdata,
    output logic    full,
    output logic    empty
);

    localparam int AW = $clog2(DEPTH);

    triple_t         mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/float_discriminant_issuer.sv
// Queues coefficient triples, issues them to the discriminant engine one
// at a time and returns tagged results; NaN/Inf triples bypass the engine.
module float_discriminant_issuer
    import float_discriminant_issuer_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64,
    parameter int TAG_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [FLEN-1:0]  in_a,
    input  logic [FLEN-1:0]  in_b,
    input  logic [FLEN-1:0]  in_c,
    output logic             eng_arg_vld,
    output logic [FLEN-1:0]  eng_a,
    output logic [FLEN-1:0]  eng_b,
    output logic [FLEN-1:0]  eng_c,
    input  logic             eng_busy,
    input  logic             eng_res_vld,
    input  logic [FLEN-1:0]  eng_res,
    input  logic             eng_res_negative,
    input  logic             eng_err,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [FLEN-1:0]  out_res,
    output logic             out_negative,
    output logic             out_err,
    output logic             out_timeout,
    output logic [TAG_W-1:0] out_tag,
    output logic             spurious
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    triple_t          head;
    triple_t          in_t;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             special;
    logic             rdy_en;
    logic [CNT_W-1:0] cnt;

    assign in_t    = '{a: in_a, b: in_b, c: in_c};
    assign in_rdy  = rdy_en & ~fifo_full;
    assign push    = in_vld & in_rdy;
    assign special = triple_special(head);
    assign pop     = (state == ISSUE)
                   | ((state == IDLE) & ~fifo_empty & special);

    float_triple_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (in_t),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rdy_en       <= 1'b0;
            cnt          <= '0;
            eng_arg_vld  <= 1'b0;
            eng_a        <= '0;
            eng_b        <= '0;
            eng_c        <= '0;
            out_vld      <= 1'b0;
            out_res      <= '0;
            out_negative <= 1'b0;
            out_err      <= 1'b0;
            out_timeout  <= 1'b0;
            out_tag      <= '0;
            spurious     <= 1'b0;
        end else begin
            rdy_en      <= 1'b1;
            eng_arg_vld <= 1'b0;
            if (eng_res_vld && state != WAIT) spurious <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        if (special) begin
                            out_res      <= '0;
                            out_err      <= 1'b1;
                            out_negative <= 1'b0;
                            out_timeout  <= 1'b0;
                            out_vld      <= 1'b1;
                            state        <= OUT;
                        end else if (!eng_busy) begin
                            eng_arg_vld <= 1'b1;
                            eng_a       <= head.a;
                            eng_b       <= head.b;
                            eng_c       <= head.c;
                            cnt         <= '0;
                            state       <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    cnt   <= cnt + 1'b1;
                    state <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    // A response on the deadline cycle still counts.
                    if (eng_res_vld) begin
                        out_res      <= eng_res;
                        out_negative <= eng_res_negative;
                        out_err      <= eng_err;
                        out_timeout  <= 1'b0;
                        out_vld      <= 1'b1;
                        state        <= OUT;
                    end else if (cnt == CNT_LAST) begin
                        out_res      <= '0;
                        out_negative <= 1'b0;
                        out_err      <= 1'b1;
                        out_timeout  <= 1'b1;
                        out_vld      <= 1'b1;
                        state        <= OUT;
                    end
                end
                OUT: begin
                    if (out_rdy) begin
                        out_vld <= 1'b0;
                        out_tag <= out_tag + TAG_W'(1);
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_float_discriminant_issuer.sv
// Directed bench for float_discriminant_issuer with a small engine stub.
module tb_float_discriminant_issuer;
    import float_discriminant_issuer_pkg::*;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;
    localparam int TAG_W   = 4;

    localparam logic [63:0] ONE   = 64'h3FF0_0000_0000_0000;
    localparam logic [63:0] TWO   = 64'h4000_0000_0000_0000;
    localparam logic [63:0] THREE = 64'h4008_0000_0000_0000;
    localparam logic [63:0] PINF  = 64'h7FF0_0000_0000_0000;
    localparam logic [63:0] NEGV  = 64'hC010_0000_0000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             in_vld;
    logic             in_rdy;
    logic [63:0]      in_a, in_b, in_c;
    logic             eng_arg_vld;
    logic [63:0]      eng_a, eng_b, eng_c;
    logic             eng_busy;
    logic             eng_res_vld;
    logic [63:0]      eng_res;
    logic             eng_res_negative;
    logic             eng_err;
    logic             out_vld;
    logic             out_rdy;
    logic [63:0]      out_res;
    logic             out_negative;
    logic             out_err;
    logic             out_timeout;
    logic [TAG_W-1:0] out_tag;
    logic             spurious;

    logic        man_vld, man_neg, man_err;
    logic [63:0] man_res;
    logic        auto_en, auto_vld, auto_neg;
    logic [63:0] auto_res;
    int          auto_idx = 0;

    assign eng_res_vld      = man_vld | auto_vld;
    assign eng_res          = auto_vld ? auto_res : man_res;
    assign eng_res_negative = auto_vld ? auto_neg : man_neg;
    assign eng_err          = auto_vld ? 1'b0 : man_err;

    logic [63:0] res_tab [6] = '{64'h4010_0000_0000_0000,
                                 64'hC000_0000_0000_0000,
                                 64'h0000_0000_0000_0000,
                                 64'h3FE0_0000_0000_0000,
                                 64'hC024_0000_0000_0000,
                                 64'h4022_0000_0000_0000};
    logic neg_tab [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    int               tests = 0;
    int               fails = 0;
    int               issue_cnt = 0;
    int               base;
    logic             collect_en = 1'b0;
    logic [63:0]      issued_b [$];
    logic [63:0]      got_res [$];
    logic [TAG_W-1:0] got_tag [$];
    logic             got_neg [$];

    float_discriminant_issuer #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT),
        .TAG_W   (TAG_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .in_vld           (in_vld),
        .in_rdy           (in_rdy),
        .in_a             (in_a),
        .in_b             (in_b),
        .in_c             (in_c),
        .eng_arg_vld      (eng_arg_vld),
        .eng_a            (eng_a),
        .eng_b            (eng_b),
        .eng_c            (eng_c),
        .eng_busy         (eng_busy),
        .eng_res_vld      (eng_res_vld),
        .eng_res          (eng_res),
        .eng_res_negative (eng_res_negative),
        .eng_err          (eng_err),
        .out_vld          (out_vld),
        .out_rdy          (out_rdy),
        .out_res          (out_res),
        .out_negative     (out_negative),
        .out_err          (out_err),
        .out_timeout      (out_timeout),
        .out_tag          (out_tag),
        .spurious         (spurious)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_triple(input logic [63:0] a, input logic [63:0] b,
                               input logic [63:0] c);
        in_vld = 1'b1;
        in_a   = a;
        in_b   = b;
        in_c   = c;
        step();
        in_vld = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    // Issue/result monitor.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (eng_arg_vld) begin
                issue_cnt++;
                issued_b.push_back(eng_b);
            end
            if (collect_en && out_vld && out_rdy) begin
                got_res.push_back(out_res);
                got_tag.push_back(out_tag);
                got_neg.push_back(out_negative);
            end
        end
    end

    // Engine stub: answers one cycle after each issue.
    initial begin
        auto_vld = 1'b0;
        auto_res = '0;
        auto_neg = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (auto_en && eng_arg_vld) begin
                @(posedge clk);
                #1;
                auto_vld = 1'b1;
                auto_res = res_tab[auto_idx % 6];
                auto_neg = neg_tab[auto_idx % 6];
                auto_idx++;
                @(posedge clk);
                #1;
                auto_vld = 1'b0;
            end
        end
    end

    initial begin
        rst = 1'b1; in_vld = 1'b0; in_a = '0; in_b = '0; in_c = '0;
        eng_busy = 1'b0; out_rdy = 1'b1; auto_en = 1'b0;
        man_vld = 1'b0; man_res = '0; man_neg = 1'b0; man_err = 1'b0;
        step();
        step();
        chk("rst_in_rdy", 64'(in_rdy), 64'd0);
        chk("rst_out_vld", 64'(out_vld), 64'd0);
        chk("rst_arg_vld", 64'(eng_arg_vld), 64'd0);
        chk("rst_out_res", out_res, 64'd0);
        chk("rst_tag", 64'(out_tag), 64'd0);
        chk("rst_spurious", 64'(spurious), 64'd0);
        chk("rst_eng_a", eng_a, 64'd0);
        rst = 1'b0;
        chk("rdy_pre", 64'(in_rdy), 64'd0);
        step();
        chk("rdy_post", 64'(in_rdy), 64'd1);

        // Basic transaction and latency.
        push_triple(ONE, THREE, TWO);
        chk("t1_arg_c1", 64'(eng_arg_vld), 64'd0);
        step();
        chk("t1_arg_c2", 64'(eng_arg_vld), 64'd1);
        chk("t1_eng_a", eng_a, ONE);
        chk("t1_eng_b", eng_b, THREE);
        chk("t1_eng_c", eng_c, TWO);
        step();
        man_vld = 1'b1; man_res = ONE; man_neg = 1'b0; man_err = 1'b0;
        step();
        man_vld = 1'b0;
        chk("t1_out_vld", 64'(out_vld), 64'd1);
        chk("t1_out_res", out_res, ONE);
        chk("t1_neg", 64'(out_negative), 64'd0);
        chk("t1_err", 64'(out_err), 64'd0);
        chk("t1_tmo", 64'(out_timeout), 64'd0);
        chk("t1_tag", 64'(out_tag), 64'd0);
        chk("t1_spurious", 64'(spurious), 64'd0);
        step();
        chk("t1_out_drop", 64'(out_vld), 64'd0);

        // Fill the queue, then stream five results.
        do_reset();
        issued_b.delete();
        base = issue_cnt;
        eng_busy = 1'b1; auto_en = 1'b1; collect_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t2_rdy_before", 64'(in_rdy), 64'd1);
            push_triple(ONE, TWO | (64'(i) << 52), TWO);
        end
        chk("t2_full", 64'(in_rdy), 64'd0);
        in_vld = 1'b1; in_a = ONE; in_b = TWO | (64'd4 << 52); in_c = TWO;
        step();
        step();
        chk("t2_still_full", 64'(in_rdy), 64'd0);
        eng_busy = 1'b0;
        for (int k = 0; k < 20 && !in_rdy; k++) step();
        chk("t2_rdy_back", 64'(in_rdy), 64'd1);
        step();
        in_vld = 1'b0;
        for (int k = 0; k < 200 && got_res.size() < 5; k++) step();
        step();
        step();
        chk("t2_results", 64'(got_res.size()), 64'd5);
        chk("t2_issues", 64'(issue_cnt - base), 64'd5);
        for (int i = 0; i < got_res.size() && i < 5; i++) begin
            chk("t2_res", got_res[i], res_tab[i]);
            chk("t2_tag", 64'(got_tag[i]), 64'(i));
            chk("t2_neg", 64'(got_neg[i]), 64'(neg_tab[i]));
        end
        for (int i = 0; i < issued_b.size() && i < 5; i++)
            chk("t2_order", issued_b[i], TWO | (64'(i) << 52));
        collect_en = 1'b0; auto_en = 1'b0;

        // NaN/Inf pre-check bypass.
        base = issue_cnt;
        push_triple(ONE, PINF, TWO);
        step();
        chk("t3_out_vld", 64'(out_vld), 64'd1);
        chk("t3_err", 64'(out_err), 64'd1);
        chk("t3_res", out_res, 64'd0);
        chk("t3_neg", 64'(out_negative), 64'd0);
        chk("t3_tmo", 64'(out_timeout), 64'd0);
        chk("t3_tag", 64'(out_tag), 64'd5);
        step();
        chk("t3_drop", 64'(out_vld), 64'd0);
        chk("t3_no_issue", 64'(issue_cnt - base), 64'd0);

        // Engine never answers.
        push_triple(ONE, THREE, TWO);
        step();
        chk("t4_arg", 64'(eng_arg_vld), 64'd1);
        repeat (TIMEOUT - 1) step();
        chk("t4_early", 64'(out_vld), 64'd0);
        step();
        chk("t4_out_vld", 64'(out_vld), 64'd1);
        chk("t4_tmo", 64'(out_timeout), 64'd1);
        chk("t4_err", 64'(out_err), 64'd1);
        chk("t4_res", out_res, 64'd0);
        chk("t4_tag", 64'(out_tag), 64'd6);
        step();
        chk("t4_drop", 64'(out_vld), 64'd0);
        auto_en = 1'b1;
        push_triple(ONE, THREE, TWO);
        step();
        chk("t4_next_arg", 64'(eng_arg_vld), 64'd1);
        step();
        step();
        chk("t4_next_vld", 64'(out_vld), 64'd1);
        chk("t4_next_res", out_res, res_tab[5]);
        chk("t4_next_tmo", 64'(out_timeout), 64'd0);
        chk("t4_next_err", 64'(out_err), 64'd0);
        chk("t4_next_tag", 64'(out_tag), 64'd7);
        step();
        auto_en = 1'b0;

        // Busy engine and a stray response in IDLE.
        eng_busy = 1'b1;
        base = issue_cnt;
        push_triple(ONE, THREE, TWO);
        repeat (4) step();
        man_vld = 1'b1; man_res = 64'h0000_0000_0000_DEAD;
        step();
        man_vld = 1'b0;
        chk("t5_spurious", 64'(spurious), 64'd1);
        chk("t5_no_out", 64'(out_vld), 64'd0);
        chk("t5_res_kept", out_res, res_tab[5]);
        chk("t5_tag_kept", 64'(out_tag), 64'd8);
        repeat (4) step();
        chk("t5_no_issue", 64'(issue_cnt - base), 64'd0);
        eng_busy = 1'b0;
        chk("t5_arg_fall", 64'(eng_arg_vld), 64'd0);
        step();
        chk("t5_arg_after", 64'(eng_arg_vld), 64'd1);
        step();
        man_vld = 1'b1; man_res = NEGV; man_neg = 1'b1; man_err = 1'b1;
        out_rdy = 1'b0;
        step();
        man_vld = 1'b0; man_neg = 1'b0; man_err = 1'b0;
        chk("t5_out_vld", 64'(out_vld), 64'd1);
        chk("t5_res", out_res, NEGV);
        chk("t5_neg", 64'(out_negative), 64'd1);
        chk("t5_err", 64'(out_err), 64'd1);
        chk("t5_tmo", 64'(out_timeout), 64'd0);
        for (int k = 0; k < 8; k++) begin
            step();
            chk("t6_hold_vld", 64'(out_vld), 64'd1);
            chk("t6_hold_res", out_res, NEGV);
            chk("t6_hold_tag", 64'(out_tag), 64'd8);
        end
        out_rdy = 1'b1;
        step();
        chk("t6_release", 64'(out_vld), 64'd0);

        // Reset while waiting on the engine.
        in_vld = 1'b1; in_a = ONE; in_b = THREE; in_c = TWO;
        step();
        in_b = TWO;
        step();
        in_vld = 1'b0;
        chk("t6_arg", 64'(eng_arg_vld), 64'd1);
        step();
        rst = 1'b1; man_vld = 1'b1; man_res = ONE;
        step();
        rst = 1'b0; man_vld = 1'b0;
        chk("t6_rst_vld", 64'(out_vld), 64'd0);
        chk("t6_rst_spur", 64'(spurious), 64'd0);
        chk("t6_rst_eng_a", eng_a, 64'd0);
        chk("t6_rst_tag", 64'(out_tag), 64'd0);
        chk("t6_rst_rdy", 64'(in_rdy), 64'd0);
        chk("t6_rst_err", 64'(out_err), 64'd0);
        base = issue_cnt;
        step();
        chk("t6_rdy_back", 64'(in_rdy), 64'd1);
        repeat (5) step();
        chk("t6_flushed", 64'(issue_cnt - base), 64'd0);
        push_triple(ONE, THREE, TWO);
        step();
        chk("t6_new_arg", 64'(eng_arg_vld), 64'd1);
        step();
        man_vld = 1'b1; man_res = ONE;
        step();
        man_vld = 1'b0;
        chk("t6_new_vld", 64'(out_vld), 64'd1);
        chk("t6_new_tag", 64'(out_tag), 64'd0);
        chk("t6_new_spur", 64'(spurious), 64'd0);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
